// File: rtl/toggle_edge_monitor.sv
// toggle_edge_monitor
// Watches the toggle flip-flop output on the shared clock. It counts every
// transition, measures the number of cycles between consecutive transitions,
// and keeps sticky flags for counter wrap and for intervals too long to
// measure. The first sample after reset or clear only primes the edge
// detector, so a level that is already high is never reported as an edge.

module toggle_edge_monitor #(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             clr,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             cnt_ovf,
    output logic             per_ovf
);

    typedef enum logic [1:0] {
        ST_PRIME      = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_MEASURE    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [PER_W-1:0] PER_ZERO  = {PER_W{1'b0}};
    localparam logic [PER_W-1:0] TIMER_MAX = {PER_W{1'b1}};
    localparam logic [PER_W-1:0] TIMER_ONE = PER_W'(1);

    // Wrapping increment of the edge counter.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        return value + CNT_W'(1);
    endfunction

    // True when the next increment of the edge counter wraps to zero.
    function automatic logic cnt_wraps(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             q_d_r;
    logic [PER_W-1:0] timer_r;
    logic             edge_s;

    logic [PER_W-1:0] timer_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [PER_W-1:0] period_nxt_s;
    logic             pv_nxt_s;
    logic             covf_nxt_s;
    logic             povf_nxt_s;

    // A transition is any difference between this sample and the previous one.
    assign edge_s = t_in ^ q_d_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_PRIME;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: clear always returns to PRIME, which reprimes the detector.
    always_comb begin
        state_nxt_s = state_r;
        if (clr) begin
            state_nxt_s = ST_PRIME;
        end else begin
            case (state_r)
                ST_PRIME: begin
                    state_nxt_s = ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    if (edge_s) begin
                        state_nxt_s = ST_MEASURE;
                    end else begin
                        state_nxt_s = ST_WAIT_FIRST;
                    end
                end
                ST_MEASURE: begin
                    state_nxt_s = ST_MEASURE;
                end
                default: begin
                    state_nxt_s = ST_PRIME;
                end
            endcase
        end
    end

    // Output/datapath next values: counting, interval timing and sticky flags.
    always_comb begin
        timer_nxt_s  = timer_r;
        cnt_nxt_s    = edge_cnt;
        period_nxt_s = period;
        pv_nxt_s     = 1'b0;
        covf_nxt_s   = cnt_ovf;
        povf_nxt_s   = per_ovf;
        if (clr) begin
            // Clear wins over an edge in the same cycle; that edge is dropped.
            timer_nxt_s  = PER_ZERO;
            cnt_nxt_s    = CNT_ZERO;
            period_nxt_s = PER_ZERO;
            covf_nxt_s   = 1'b0;
            povf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_PRIME: begin
                    // Only the sample is captured here; nothing is counted.
                    timer_nxt_s = timer_r;
                end
                ST_WAIT_FIRST: begin
                    if (edge_s) begin
                        // First edge starts the timer but has nothing to measure against.
                        cnt_nxt_s   = cnt_inc(edge_cnt);
                        covf_nxt_s  = cnt_ovf | cnt_wraps(edge_cnt);
                        timer_nxt_s = TIMER_ONE;
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                ST_MEASURE: begin
                    if (edge_s) begin
                        period_nxt_s = timer_r;
                        pv_nxt_s     = 1'b1;
                        cnt_nxt_s    = cnt_inc(edge_cnt);
                        covf_nxt_s   = cnt_ovf | cnt_wraps(edge_cnt);
                        timer_nxt_s  = TIMER_ONE;
                    end else if (timer_r != TIMER_MAX) begin
                        timer_nxt_s = timer_r + PER_W'(1);
                    end else begin
                        // Timer pinned at all-ones: interval is too long, report it saturated.
                        timer_nxt_s = timer_r;
                        povf_nxt_s  = 1'b1;
                    end
                end
                default: begin
                    timer_nxt_s  = PER_ZERO;
                    cnt_nxt_s    = CNT_ZERO;
                    period_nxt_s = PER_ZERO;
                    covf_nxt_s   = 1'b0;
                    povf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // Datapath and registered outputs; the sample register follows t_in every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_d_r        <= 1'b0;
            timer_r      <= PER_ZERO;
            edge_cnt     <= CNT_ZERO;
            period       <= PER_ZERO;
            period_valid <= 1'b0;
            cnt_ovf      <= 1'b0;
            per_ovf      <= 1'b0;
        end else begin
            q_d_r        <= t_in;
            timer_r      <= timer_nxt_s;
            edge_cnt     <= cnt_nxt_s;
            period       <= period_nxt_s;
            period_valid <= pv_nxt_s;
            cnt_ovf      <= covf_nxt_s;
            per_ovf      <= povf_nxt_s;
        end
    end

endmodule

// File: tb/tb_toggle_edge_monitor.sv
// Testbench for toggle_edge_monitor. A cycle-stamp model (edge times,
// total edge count) predicts every output; a compare process checks the DUT
// against it on every falling edge, and directed scenarios pin known values.

module tb_toggle_edge_monitor;

    localparam int CNT_W   = 4;
    localparam int PER_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int PER_MAX = (1 << PER_W) - 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             t_in  = 1'b0;
    logic             clr   = 1'b0;
    logic [CNT_W-1:0] edge_cnt;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             cnt_ovf;
    logic             per_ovf;

    toggle_edge_monitor #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .t_in         (t_in),
        .clr          (clr),
        .edge_cnt     (edge_cnt),
        .period       (period),
        .period_valid (period_valid),
        .cnt_ovf      (cnt_ovf),
        .per_ovf      (per_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: cycle index, time of last edge, total number of edges since clear.
    int m_cyc       = 0;
    bit m_primed    = 1'b0;
    bit m_prev      = 1'b0;
    bit m_have_edge = 1'b0;
    int m_last      = 0;
    int m_edges     = 0;
    int m_period    = 0;
    bit m_pv        = 1'b0;
    bit m_povf      = 1'b0;

    // Model update on every clock, or immediately on reset.
    always @(posedge clk or negedge reset) begin
        if (!reset || clr) begin
            m_cyc = 0; m_primed = 1'b0; m_have_edge = 1'b0; m_last = 0;
            m_edges = 0; m_period = 0; m_pv = 1'b0; m_povf = 1'b0;
        end else begin
            m_cyc++;
            m_pv = 1'b0;
            if (!m_primed) begin
                m_primed = 1'b1;
            end else if (t_in != m_prev) begin
                if (m_have_edge) begin
                    m_period = (m_cyc - m_last > PER_MAX) ? PER_MAX : (m_cyc - m_last);
                    m_pv = 1'b1;
                end
                m_have_edge = 1'b1;
                m_last = m_cyc;
                m_edges++;
            end else if (m_have_edge && (m_cyc - m_last) >= PER_MAX) begin
                m_povf = 1'b1;
            end
        end
        m_prev = t_in;
    end

    bit chk_en  = 1'b0;
    int pv_seen = 0;
    int per_log[$];

    // Compare all outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("edge_cnt", int'(edge_cnt), m_edges % CNT_MOD);
            check("period", int'(period), m_period);
            check("period_valid", int'(period_valid), int'(m_pv));
            check("cnt_ovf", int'(cnt_ovf), int'(m_edges >= CNT_MOD));
            check("per_ovf", int'(per_ovf), int'(m_povf));
            if (period_valid) begin
                pv_seen++;
                per_log.push_back(int'(period));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int sel;
    int prob;

    initial begin
        #1 reset = 1'b0;
        t_in = 1'b1;
        #1 chk_en = 1'b1;
        tick(); tick();
        check("rst_edge_cnt", int'(edge_cnt), 0);
        check("rst_period", int'(period), 0);
        check("rst_flags", int'({period_valid, cnt_ovf, per_ovf}), 0);

        // High out of reset is never an edge.
        reset = 1'b1;
        repeat (5) tick();
        check("hi5_edge_cnt", int'(edge_cnt), 0);
        check("hi5_pv_seen", pv_seen, 0);
        check("hi5_flags", int'({cnt_ovf, per_ovf}), 0);

        // Toggle every cycle for 10 cycles.
        pv_seen = 0;
        per_log.delete();
        for (int i = 0; i < 10; i++) begin
            t_in = ~t_in;
            tick();
        end
        check("tog_edge_cnt", int'(edge_cnt), 10);
        check("tog_pv_seen", pv_seen, 9);
        foreach (per_log[i]) check("tog_period", per_log[i], 1);

        // Pattern high 3, low 5, high 2, then low.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pv_seen = 0;
        per_log.delete();
        t_in = 1'b1; repeat (3) tick();
        t_in = 1'b0; repeat (5) tick();
        t_in = 1'b1; repeat (2) tick();
        t_in = 1'b0; tick();
        check("pat_edge_cnt", int'(edge_cnt), 3);
        check("pat_pv_seen", per_log.size(), 2);
        if (per_log.size() >= 2) begin
            check("pat_period_a", per_log[0], 5);
            check("pat_period_b", per_log[1], 2);
        end

        // Long constant interval saturates the timer.
        repeat (20) tick();
        check("sat_per_ovf", int'(per_ovf), 1);
        t_in = 1'b1;
        tick();
        check("sat_period", int'(period), 15);
        check("sat_pv", int'(period_valid), 1);
        check("sat_edge_cnt", int'(edge_cnt), 4);

        // Counter wrap, then clear coinciding with an edge.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            t_in = ~t_in;
            tick();
        end
        check("wrap_edge_cnt", int'(edge_cnt), 1);
        check("wrap_cnt_ovf", int'(cnt_ovf), 1);
        clr = 1'b1;
        t_in = ~t_in;
        tick();
        clr = 1'b0;
        check("clr_edge_cnt", int'(edge_cnt), 0);
        check("clr_flags", int'({cnt_ovf, per_ovf, period_valid}), 0);
        check("clr_period", int'(period), 0);
        t_in = ~t_in;
        tick();
        check("prime_no_count", int'(edge_cnt), 0);
        t_in = ~t_in;
        tick();
        check("prime_then_count", int'(edge_cnt), 1);

        // Asynchronous reset in the middle of a measurement.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            t_in = ~t_in;
            tick();
        end
        check("mid_edge_cnt", int'(edge_cnt), 6);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_edge_cnt", int'(edge_cnt), 0);
        check("async_period", int'(period), 0);
        check("async_flags", int'({period_valid, cnt_ovf, per_ovf}), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        t_in = ~t_in;
        tick();
        check("post_rst_edge_cnt", int'(edge_cnt), 1);

        // Randomized segments with varying toggle density, clears and resets.
        sel = 0;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) sel = int'($urandom_range(0, 3));
            case (sel)
                0:       prob = 2;
                1:       prob = 10;
                2:       prob = 40;
                default: prob = 95;
            endcase
            clr = ($urandom_range(0, 49) == 0);
            if (int'($urandom_range(0, 99)) < prob) t_in = ~t_in;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end
        clr = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_edge_monitor.md
# toggle_edge_monitor

Downstream consumer of the toggle flip-flop output stage. Samples the flip-flop's `q` on the shared clock, detects every transition, counts them, and measures the interval in clock cycles between consecutive transitions. Gives the lab bench and downstream display logic a registered edge count, the last measured toggle period, and sticky overflow flags.

## Interface
- `CNT_W`, default 8: width of the edge counter.
- `PER_W`, default 8: width of the period timer and of the reported period.

- `clk`  in  1  rising-edge clock, shared with the toggle flip-flop.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `t_in`  in  1  toggle flip-flop `q`, synchronous to `clk`.
- `clr`  in  1  synchronous clear; same effect as reset, applied at the next rising edge.
- `edge_cnt`  out  CNT_W  number of detected transitions, modulo 2^CNT_W.
- `period`  out  PER_W  cycles between the last two detected transitions, saturating.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `cnt_ovf`  out  1  sticky; set when `edge_cnt` wraps from all-ones to 0.
- `per_ovf`  out  1  sticky; set when a measured interval exceeds 2^PER_W-1.

## Operation
- Registers:
  - `q_d`: previous sample of `t_in`.
  - `timer`: PER_W bits.
  - State machine with states PRIME, WAIT_FIRST, MEASURE.
- Edge detect: `edge = (t_in != q_d)`. Only evaluated in WAIT_FIRST and MEASURE.
- `q_d <= t_in` every cycle, in every state.
- PRIME (reset state):
  - Captures `t_in` into `q_d` and counts nothing.
  - Goes to WAIT_FIRST unconditionally.
  - Purpose: a `t_in` that is high out of reset is never counted as an edge.
- WAIT_FIRST:
  - On `edge`: `edge_cnt` increments, `timer` <= 1, next state MEASURE. No `period_valid`, because there is no prior edge to measure from.
  - No edge: hold.
- MEASURE:
  - On `edge`:
    - `period` <= `timer`.
    - `period_valid` <= 1.
    - `edge_cnt` increments.
    - `timer` <= 1.
  - No edge, `timer` < all-ones: `timer` increments.
  - No edge, `timer` == all-ones: `timer` holds and `per_ovf` is set. The interval being measured is then reported as all-ones.
- `edge_cnt` wraps at all-ones -> 0. `cnt_ovf` is set on that same edge.
- Sticky flags are cleared only by `reset` or `clr`.
- `clr`:
  - Next state PRIME.
  - `edge_cnt`, `period`, `timer`, `period_valid`, `cnt_ovf`, `per_ovf` all go to 0.
  - `clr` has priority over an edge in the same cycle; that edge is not counted.
- Reset mid-measurement: all outputs drop to 0 asynchronously. Counting resumes via PRIME after reset is released.

## Timing
- Reset values: `edge_cnt`=0, `period`=0, `period_valid`=0, `cnt_ovf`=0, `per_ovf`=0, state PRIME, `q_d`=0, `timer`=0.
- Latency: `t_in` changes before rising edge k -> edge detected at edge k -> `edge_cnt`/`period`/`period_valid` visible after edge k (1 cycle).
- `period_valid` is high for exactly one cycle per measured edge. It stays high on consecutive cycles if edges occur every cycle.
- `t_in` toggling every cycle (flip-flop driven with t=1 constantly) -> `period`=1 on every edge after the first.
- `t_in` constant -> no pulses. `timer` saturates at 2^PER_W-1 after that many cycles, then `per_ovf` rises one cycle later.
- `clr` and `reset` are level inputs; holding either keeps the block in its cleared state.

## Test plan
- Reset asserted with `t_in`=1, then released; `t_in` held at 1 for 5 cycles -> `edge_cnt`=0, no `period_valid`, all flags 0.
- `t_in` toggles every cycle for 10 cycles -> `edge_cnt`=10; 9 `period_valid` pulses, each with `period`=1.
- `t_in` pattern high 3, low 5, high 2 cycles -> `period` reported 5, then 2; `edge_cnt`=3 (first edge counted, not measured).
- PER_W=4, `t_in` constant for 20 cycles after the first edge -> `per_ovf`=1; `period`=15 on the next edge, `period_valid` pulses.
- CNT_W=4, 17 edges -> `edge_cnt`=1, `cnt_ovf`=1; then `clr` for 1 cycle, coinciding with an edge -> `edge_cnt`=0, both flags 0, state PRIME.
- `reset` asserted between clock edges in MEASURE with `edge_cnt`=6 -> outputs 0 immediately, without waiting for `clk`. After release, the first `t_in` change after PRIME is counted as `edge_cnt`=1.
